// File: rtl/ie_fetch_predecode.sv
// 6502 fetch front end: reads opcode/operand bytes, sizes each instruction,
// predecodes it into the simple-op bundle and hands it to IE over valid/ready.
module ie_fetch_predecode #(
    parameter logic [15:0] RESET_PC   = 16'h8000,
    parameter bit          AUTO_START = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    output logic        mem_rd_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rd_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst_pc,
    output logic [7:0]  inst_opcode,
    output logic [1:0]  inst_len,
    output logic [15:0] operand,
    output logic [7:0]  simple_op,
    output logic        mem_load_flag,
    output logic [2:0]  store_flag,
    output logic [1:0]  reg_load_flag,
    output logic [3:0]  alu_op,
    output logic        immediate_flag,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_OP = 3'd1,
        S_FETCH_LO = 3'd2,
        S_FETCH_HI = 3'd3,
        S_PRESENT  = 3'd4
    } state_t;

    localparam state_t RESET_STATE = AUTO_START ? S_FETCH_OP : S_IDLE;

    localparam logic [7:0] SOP_NOP    = 8'h00;
    localparam logic [7:0] SOP_LD     = 8'h01;
    localparam logic [7:0] SOP_ST     = 8'h02;
    localparam logic [7:0] SOP_ALU    = 8'h03;
    localparam logic [7:0] SOP_XFER   = 8'h04;
    localparam logic [7:0] SOP_INCDEC = 8'h05;
    localparam logic [7:0] SOP_CMP    = 8'h06;
    localparam logic [7:0] SOP_SHIFT  = 8'h07;
    localparam logic [7:0] SOP_JMP    = 8'h08;
    localparam logic [7:0] SOP_JSR    = 8'h09;
    localparam logic [7:0] SOP_RTS    = 8'h0A;
    localparam logic [7:0] SOP_BRANCH = 8'h0B;
    localparam logic [7:0] SOP_FLAG   = 8'h0C;
    localparam logic [7:0] SOP_BRK    = 8'h0D;
    localparam logic [7:0] SOP_RTI    = 8'h0E;
    localparam logic [7:0] SOP_BIT    = 8'h0F;
    localparam logic [7:0] SOP_PUSH   = 8'h10;
    localparam logic [7:0] SOP_PULL   = 8'h11;

    localparam logic [2:0] ST_NONE = 3'b000;
    localparam logic [2:0] ST_MEM  = 3'b001;
    localparam logic [2:0] ST_A    = 3'b010;
    localparam logic [2:0] ST_X    = 3'b011;
    localparam logic [2:0] ST_Y    = 3'b100;

    localparam logic [1:0] RL_MEM = 2'b00;
    localparam logic [1:0] RL_A   = 2'b01;
    localparam logic [1:0] RL_X   = 2'b10;
    localparam logic [1:0] RL_Y   = 2'b11;

    localparam logic [3:0] ALU_PASS = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_AND  = 4'h3;
    localparam logic [3:0] ALU_OR   = 4'h4;
    localparam logic [3:0] ALU_EOR  = 4'h5;
    localparam logic [3:0] ALU_INC  = 4'h6;
    localparam logic [3:0] ALU_DEC  = 4'h7;
    localparam logic [3:0] ALU_ASL  = 4'h8;
    localparam logic [3:0] ALU_LSR  = 4'h9;
    localparam logic [3:0] ALU_ROL  = 4'hA;
    localparam logic [3:0] ALU_ROR  = 4'hB;
    localparam logic [3:0] ALU_CMP  = 4'hC;
    localparam logic [3:0] ALU_BIT  = 4'hD;

    typedef struct packed {
        logic [7:0] sop;
        logic       mem_ld;
        logic [2:0] st;
        logic [1:0] rl;
        logic [3:0] alu;
        logic       imm;
    } op_fields_t;

    function automatic op_fields_t mk(input logic [7:0] sop, input logic mem_ld,
                                      input logic [2:0] st, input logic [1:0] rl,
                                      input logic [3:0] alu, input logic imm);
        op_fields_t f;
        f.sop    = sop;
        f.mem_ld = mem_ld;
        f.st     = st;
        f.rl     = rl;
        f.alu    = alu;
        f.imm    = imm;
        return f;
    endfunction

    function automatic logic [1:0] inst_len_of(input logic [7:0] op);
        logic [1:0] len;
        if (op[3:0] == 4'h8 || op[3:0] == 4'hA || op == 8'h00 || op == 8'h40 || op == 8'h60) begin
            len = 2'd0;
        end else if (op[3:0] == 4'hC || op[3:0] == 4'hD || op[3:0] == 4'hE ||
                     (op[3:0] == 4'h9 && op[4]) || op == 8'h20) begin
            len = 2'd2;
        end else begin
            len = 2'd1;
        end
        return len;
    endfunction

    // Group-01 opcodes (ORA..SBC) decode by aaa; everything else is listed; unknown -> all zero.
    function automatic op_fields_t decode_op(input logic [7:0] op);
        op_fields_t f;
        logic       imm;
        imm = (op[4:2] == 3'b010);
        f   = '0;
        if (op[1:0] == 2'b01) begin
            case (op[7:5])
                3'b000:  f = mk(SOP_ALU, ~imm, ST_A, RL_MEM, ALU_OR, imm);
                3'b001:  f = mk(SOP_ALU, ~imm, ST_A, RL_MEM, ALU_AND, imm);
                3'b010:  f = mk(SOP_ALU, ~imm, ST_A, RL_MEM, ALU_EOR, imm);
                3'b011:  f = mk(SOP_ALU, ~imm, ST_A, RL_MEM, ALU_ADD, imm);
                3'b100: begin
                    if (imm) begin
                        f = '0;
                    end else begin
                        f = mk(SOP_ST, 1'b0, ST_MEM, RL_A, ALU_PASS, 1'b0);
                    end
                end
                3'b101:  f = mk(SOP_LD, ~imm, ST_A, RL_MEM, ALU_PASS, imm);
                3'b110:  f = mk(SOP_CMP, ~imm, ST_NONE, RL_MEM, ALU_CMP, imm);
                3'b111:  f = mk(SOP_ALU, ~imm, ST_A, RL_MEM, ALU_SUB, imm);
                default: f = '0;
            endcase
        end else begin
            case (op)
                8'hA2:                      f = mk(SOP_LD, 1'b0, ST_X, RL_MEM, ALU_PASS, 1'b1);
                8'hA0:                      f = mk(SOP_LD, 1'b0, ST_Y, RL_MEM, ALU_PASS, 1'b1);
                8'hA6, 8'hAE, 8'hB6, 8'hBE: f = mk(SOP_LD, 1'b1, ST_X, RL_MEM, ALU_PASS, 1'b0);
                8'hA4, 8'hAC, 8'hB4, 8'hBC: f = mk(SOP_LD, 1'b1, ST_Y, RL_MEM, ALU_PASS, 1'b0);
                8'h86, 8'h8E, 8'h96:        f = mk(SOP_ST, 1'b0, ST_MEM, RL_X, ALU_PASS, 1'b0);
                8'h84, 8'h8C, 8'h94:        f = mk(SOP_ST, 1'b0, ST_MEM, RL_Y, ALU_PASS, 1'b0);
                8'hAA:                      f = mk(SOP_XFER, 1'b0, ST_X, RL_A, ALU_PASS, 1'b0);
                8'hA8:                      f = mk(SOP_XFER, 1'b0, ST_Y, RL_A, ALU_PASS, 1'b0);
                8'h8A:                      f = mk(SOP_XFER, 1'b0, ST_A, RL_X, ALU_PASS, 1'b0);
                8'h98:                      f = mk(SOP_XFER, 1'b0, ST_A, RL_Y, ALU_PASS, 1'b0);
                8'hE8:                      f = mk(SOP_INCDEC, 1'b0, ST_X, RL_X, ALU_INC, 1'b0);
                8'hC8:                      f = mk(SOP_INCDEC, 1'b0, ST_Y, RL_Y, ALU_INC, 1'b0);
                8'hCA:                      f = mk(SOP_INCDEC, 1'b0, ST_X, RL_X, ALU_DEC, 1'b0);
                8'h88:                      f = mk(SOP_INCDEC, 1'b0, ST_Y, RL_Y, ALU_DEC, 1'b0);
                8'h0A:                      f = mk(SOP_SHIFT, 1'b0, ST_A, RL_A, ALU_ASL, 1'b0);
                8'h4A:                      f = mk(SOP_SHIFT, 1'b0, ST_A, RL_A, ALU_LSR, 1'b0);
                8'h2A:                      f = mk(SOP_SHIFT, 1'b0, ST_A, RL_A, ALU_ROL, 1'b0);
                8'h6A:                      f = mk(SOP_SHIFT, 1'b0, ST_A, RL_A, ALU_ROR, 1'b0);
                8'h06, 8'h0E:               f = mk(SOP_SHIFT, 1'b1, ST_MEM, RL_MEM, ALU_ASL, 1'b0);
                8'h46, 8'h4E:               f = mk(SOP_SHIFT, 1'b1, ST_MEM, RL_MEM, ALU_LSR, 1'b0);
                8'hE0:                      f = mk(SOP_CMP, 1'b0, ST_NONE, RL_X, ALU_CMP, 1'b1);
                8'hC0:                      f = mk(SOP_CMP, 1'b0, ST_NONE, RL_Y, ALU_CMP, 1'b1);
                8'hE4, 8'hEC:               f = mk(SOP_CMP, 1'b1, ST_NONE, RL_X, ALU_CMP, 1'b0);
                8'hC4, 8'hCC:               f = mk(SOP_CMP, 1'b1, ST_NONE, RL_Y, ALU_CMP, 1'b0);
                8'h24, 8'h2C:               f = mk(SOP_BIT, 1'b1, ST_NONE, RL_A, ALU_BIT, 1'b0);
                8'h4C:                      f = mk(SOP_JMP, 1'b0, ST_NONE, RL_MEM, ALU_PASS, 1'b0);
                8'h6C:                      f = mk(SOP_JMP, 1'b1, ST_NONE, RL_MEM, ALU_PASS, 1'b0);
                8'h20:                      f = mk(SOP_JSR, 1'b0, ST_MEM, RL_MEM, ALU_PASS, 1'b0);
                8'h60:                      f = mk(SOP_RTS, 1'b1, ST_NONE, RL_MEM, ALU_PASS, 1'b0);
                8'h40:                      f = mk(SOP_RTI, 1'b1, ST_NONE, RL_MEM, ALU_PASS, 1'b0);
                8'h00:                      f = mk(SOP_BRK, 1'b0, ST_MEM, RL_MEM, ALU_PASS, 1'b0);
                8'h10, 8'h30, 8'h50, 8'h70,
                8'h90, 8'hB0, 8'hD0, 8'hF0: f = mk(SOP_BRANCH, 1'b0, ST_NONE, RL_MEM, ALU_PASS, 1'b0);
                8'h18, 8'h38, 8'h58, 8'h78,
                8'hB8, 8'hD8, 8'hF8:        f = mk(SOP_FLAG, 1'b0, ST_NONE, RL_MEM, ALU_PASS, 1'b0);
                8'h48:                      f = mk(SOP_PUSH, 1'b0, ST_MEM, RL_A, ALU_PASS, 1'b0);
                8'h68:                      f = mk(SOP_PULL, 1'b1, ST_A, RL_MEM, ALU_PASS, 1'b0);
                8'hEA:                      f = mk(SOP_NOP, 1'b0, ST_NONE, RL_MEM, ALU_PASS, 1'b0);
                default:                    f = '0;
            endcase
        end
        return f;
    endfunction

    state_t      state_q, state_d;
    logic        discard_q, discard_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic        mem_rd_req_q, mem_rd_req_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic        busy_q, busy_d;
    logic [15:0] inst_pc_q, inst_pc_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [1:0]  inst_len_q, inst_len_d;
    logic [15:0] operand_q, operand_d;
    op_fields_t  fields_q, fields_d;

    logic        rd_done_s;
    logic        rd_pending_s;
    logic        accept_s;
    logic        capture_s;
    logic [1:0]  len_s;
    op_fields_t  dec_s;

    assign rd_done_s    = mem_rd_req_q & mem_ack;
    assign rd_pending_s = mem_rd_req_q & ~mem_ack;
    assign accept_s     = inst_valid_q & inst_ready;
    // A redirect or a pending discard makes the returning byte stale.
    assign capture_s    = rd_done_s & ~discard_q & ~pc_load;
    assign len_s        = inst_len_of(mem_rd_data);
    assign dec_s        = decode_op(mem_rd_data);

    // FSM state, stale-read discard flag and sequential fetch address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            discard_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Next-state and fetch-address selection; pc_load overrides everything
    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        fetch_pc_d = fetch_pc_q;
        if (pc_load) begin
            state_d    = S_FETCH_OP;
            discard_d  = rd_pending_s;
            fetch_pc_d = pc_load_val;
        end else if (discard_q) begin
            state_d   = S_FETCH_OP;
            discard_d = ~rd_done_s;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_FETCH_OP: begin
                    if (rd_done_s) begin
                        state_d = (len_s == 2'd0) ? S_PRESENT : S_FETCH_LO;
                    end else begin
                        state_d = S_FETCH_OP;
                    end
                end
                S_FETCH_LO: begin
                    if (rd_done_s) begin
                        state_d = (inst_len_q == 2'd2) ? S_FETCH_HI : S_PRESENT;
                    end else begin
                        state_d = S_FETCH_LO;
                    end
                end
                S_FETCH_HI: begin
                    if (rd_done_s) begin
                        state_d = S_PRESENT;
                    end else begin
                        state_d = S_FETCH_HI;
                    end
                end
                S_PRESENT: begin
                    if (accept_s) begin
                        state_d    = S_FETCH_OP;
                        fetch_pc_d = inst_pc_q + 16'd1 + {14'd0, inst_len_q};
                    end else begin
                        state_d = S_PRESENT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs: byte capture, request/address, valid, busy
    always_comb begin
        inst_pc_d    = inst_pc_q;
        opcode_d     = opcode_q;
        inst_len_d   = inst_len_q;
        operand_d    = operand_q;
        fields_d     = fields_q;
        mem_rd_req_d = 1'b0;
        mem_addr_d   = mem_addr_q;
        if (capture_s) begin
            case (state_q)
                S_FETCH_OP: begin
                    inst_pc_d  = fetch_pc_q;
                    opcode_d   = mem_rd_data;
                    inst_len_d = len_s;
                    operand_d  = 16'h0000;
                    fields_d   = dec_s;
                end
                S_FETCH_LO: operand_d[7:0]  = mem_rd_data;
                S_FETCH_HI: operand_d[15:8] = mem_rd_data;
                default:    operand_d       = operand_q;
            endcase
        end else begin
            operand_d = operand_q;
        end
        // An outstanding read keeps request and address frozen until its ack.
        if (rd_pending_s) begin
            mem_rd_req_d = 1'b1;
            mem_addr_d   = mem_addr_q;
        end else begin
            case (state_d)
                S_FETCH_OP: begin
                    mem_rd_req_d = 1'b1;
                    mem_addr_d   = fetch_pc_d;
                end
                S_FETCH_LO: begin
                    mem_rd_req_d = 1'b1;
                    mem_addr_d   = inst_pc_d + 16'd1;
                end
                S_FETCH_HI: begin
                    mem_rd_req_d = 1'b1;
                    mem_addr_d   = inst_pc_d + 16'd2;
                end
                default: begin
                    mem_rd_req_d = 1'b0;
                    mem_addr_d   = mem_addr_q;
                end
            endcase
        end
        inst_valid_d = (state_d == S_PRESENT);
        busy_d       = (state_d != S_IDLE);
    end

    // Output and instruction-bundle registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd_req_q <= 1'b0;
            mem_addr_q   <= 16'h0000;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            inst_pc_q    <= 16'h0000;
            opcode_q     <= 8'h00;
            inst_len_q   <= 2'd0;
            operand_q    <= 16'h0000;
            fields_q     <= '0;
        end else begin
            mem_rd_req_q <= mem_rd_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_valid_q <= inst_valid_d;
            busy_q       <= busy_d;
            inst_pc_q    <= inst_pc_d;
            opcode_q     <= opcode_d;
            inst_len_q   <= inst_len_d;
            operand_q    <= operand_d;
            fields_q     <= fields_d;
        end
    end

    assign mem_rd_req     = mem_rd_req_q;
    assign mem_addr       = mem_addr_q;
    assign inst_valid     = inst_valid_q;
    assign busy           = busy_q;
    assign inst_pc        = inst_pc_q;
    assign inst_opcode    = opcode_q;
    assign inst_len       = inst_len_q;
    assign operand        = operand_q;
    assign simple_op      = fields_q.sop;
    assign mem_load_flag  = fields_q.mem_ld;
    assign store_flag     = fields_q.st;
    assign reg_load_flag  = fields_q.rl;
    assign alu_op         = fields_q.alu;
    assign immediate_flag = fields_q.imm;

endmodule

// File: tb/tb_ie_fetch_predecode.sv
// Directed bench for ie_fetch_predecode (AUTO_START=1) with a byte-memory
// responder whose ack latency is programmable.
module tb_ie_fetch_predecode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        inst_ready = 1'b0;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic        inst_valid;
    logic [15:0] inst_pc;
    logic [7:0]  inst_opcode;
    logic [1:0]  inst_len;
    logic [15:0] operand;
    logic [7:0]  simple_op;
    logic        mem_load_flag;
    logic [2:0]  store_flag;
    logic [1:0]  reg_load_flag;
    logic [3:0]  alu_op;
    logic        immediate_flag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:65535];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          hold_viol = 0;
    int          ack_cnt = 0;
    logic        prev_out = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    logic [15:0] ack_log [0:63];
    logic [61:0] bundle_s;

    ie_fetch_predecode #(.RESET_PC(16'h8000), .AUTO_START(1'b1)) dut (
        .clk(clk), .rst(rst), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rd_data(mem_rd_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_pc(inst_pc), .inst_opcode(inst_opcode), .inst_len(inst_len),
        .operand(operand), .simple_op(simple_op), .mem_load_flag(mem_load_flag),
        .store_flag(store_flag), .reg_load_flag(reg_load_flag), .alu_op(alu_op),
        .immediate_flag(immediate_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    assign bundle_s = {inst_pc, inst_opcode, inst_len, operand, simple_op, mem_load_flag,
                       store_flag, reg_load_flag, alu_op, immediate_flag, inst_valid};

    // Memory responder: acks after ack_delay waiting cycles, logs acked addresses,
    // and counts any request withdrawn or re-addressed before its ack.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack  <= 1'b0;
            wait_cnt <= 0;
            prev_out <= 1'b0;
        end else begin
            if (prev_out && (mem_rd_req !== 1'b1 || mem_addr !== prev_addr))
                hold_viol <= hold_viol + 1;
            if (mem_rd_req === 1'b1 && wait_cnt >= ack_delay) begin
                mem_ack               <= 1'b1;
                mem_rd_data           <= mem[mem_addr];
                wait_cnt              <= 0;
                ack_log[ack_cnt % 64] <= mem_addr;
                ack_cnt               <= ack_cnt + 1;
                prev_out              <= 1'b0;
            end else if (mem_rd_req === 1'b1) begin
                mem_ack  <= 1'b0;
                wait_cnt <= wait_cnt + 1;
                prev_out <= 1'b1;
            end else begin
                mem_ack  <= 1'b0;
                wait_cnt <= 0;
                prev_out <= 1'b0;
            end
            prev_addr <= mem_addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (inst_valid !== 1'b1 && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic accept();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          base;
        int          chg;
        int          reqs;
        int          held_bad;
        int          stale;
        logic [61:0] snap;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42;
        mem[16'h8002] = 8'h8D; mem[16'h8003] = 8'h00; mem[16'h8004] = 8'h20;
        mem[16'h8005] = 8'hE8;
        mem[16'hFFFF] = 8'hAD; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
        mem[16'hC000] = 8'hAD; mem[16'hC001] = 8'h78; mem[16'hC002] = 8'h56;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {63'd0, mem_rd_req}, 64'd0);
        chk("rst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_addr", {48'd0, mem_addr}, 64'd0);
        chk("rst_operand", {48'd0, operand}, 64'd0);
        rst = 1'b0;

        // Auto-start at 8000: LDA #$42
        wait_valid(n);
        chk("a9_valid", {63'd0, inst_valid}, 64'd1);
        chk("a9_pc", {48'd0, inst_pc}, 64'h8000);
        chk("a9_opcode", {56'd0, inst_opcode}, 64'hA9);
        chk("a9_len", {62'd0, inst_len}, 64'd1);
        chk("a9_operand", {48'd0, operand}, 64'h0042);
        chk("a9_imm", {63'd0, immediate_flag}, 64'd1);
        chk("a9_sop", {56'd0, simple_op}, 64'h01);
        chk("a9_store", {61'd0, store_flag}, 64'd2);
        chk("a9_memld", {63'd0, mem_load_flag}, 64'd0);
        chk("a9_nacks", ack_cnt, 64'd2);
        chk("a9_ack0", {48'd0, ack_log[0]}, 64'h8000);
        chk("a9_ack1", {48'd0, ack_log[1]}, 64'h8001);

        // Backpressure for 5 cycles
        snap = bundle_s;
        chg  = 0;
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bundle_s !== snap) chg++;
            if (mem_rd_req !== 1'b0) reqs++;
        end
        chk("bp_stable", chg, 64'd0);
        chk("bp_no_req", reqs, 64'd0);
        accept();
        chk("acc_valid_drop", {63'd0, inst_valid}, 64'd0);
        chk("acc_req", {63'd0, mem_rd_req}, 64'd1);
        chk("acc_next_addr", {48'd0, mem_addr}, 64'h8002);
        chk("acc_busy", {63'd0, busy}, 64'd1);

        // STA $2000 then INX
        base = ack_cnt;
        wait_valid(n);
        chk("8d_latency", n, 64'd3);
        chk("8d_opcode", {56'd0, inst_opcode}, 64'h8D);
        chk("8d_pc", {48'd0, inst_pc}, 64'h8002);
        chk("8d_len", {62'd0, inst_len}, 64'd2);
        chk("8d_operand", {48'd0, operand}, 64'h2000);
        chk("8d_store", {61'd0, store_flag}, 64'd1);
        chk("8d_regld", {62'd0, reg_load_flag}, 64'd1);
        chk("8d_nacks", ack_cnt - base, 64'd3);
        chk("8d_ack2", {48'd0, ack_log[(base + 2) % 64]}, 64'h8004);
        accept();
        wait_valid(n);
        chk("e8_latency", n, 64'd1);
        chk("e8_opcode", {56'd0, inst_opcode}, 64'hE8);
        chk("e8_pc", {48'd0, inst_pc}, 64'h8005);
        chk("e8_len", {62'd0, inst_len}, 64'd0);
        chk("e8_operand", {48'd0, operand}, 64'h0000);
        chk("e8_store", {61'd0, store_flag}, 64'd3);
        chk("e8_alu", {60'd0, alu_op}, 64'd6);

        // Redirect to FFFF while E8 is presented: bundle dropped, wrap to 0000
        pc_load_val = 16'hFFFF;
        pc_load     = 1'b1;
        step();
        pc_load = 1'b0;
        chk("jmp_valid_drop", {63'd0, inst_valid}, 64'd0);
        chk("jmp_addr", {48'd0, mem_addr}, 64'hFFFF);
        base = ack_cnt;
        wait_valid(n);
        chk("wrap_opcode", {56'd0, inst_opcode}, 64'hAD);
        chk("wrap_pc", {48'd0, inst_pc}, 64'hFFFF);
        chk("wrap_operand", {48'd0, operand}, 64'h1234);
        chk("wrap_memld", {63'd0, mem_load_flag}, 64'd1);
        chk("wrap_ack1", {48'd0, ack_log[(base + 1) % 64]}, 64'h0000);
        chk("wrap_ack2", {48'd0, ack_log[(base + 2) % 64]}, 64'h0001);
        accept();
        ack_delay = 4;
        chk("wrap_next_addr", {48'd0, mem_addr}, 64'h0002);

        // Abort: pc_load C000 in cycle 2 of a 4-cycle-delayed read of 0002
        step();
        pc_load_val = 16'hC000;
        pc_load     = 1'b1;
        step();
        pc_load  = 1'b0;
        n        = 0;
        held_bad = 0;
        stale    = 0;
        while (mem_addr === 16'h0002 && n < 12) begin
            if (mem_rd_req !== 1'b1) held_bad++;
            if (inst_valid !== 1'b0) stale++;
            step();
            n++;
        end
        chk("abort_held", held_bad, 64'd0);
        chk("abort_hold_cycles", n, 64'd3);
        chk("abort_new_addr", {48'd0, mem_addr}, 64'hC000);
        chk("abort_new_req", {63'd0, mem_rd_req}, 64'd1);
        chk("abort_acked_old", {48'd0, ack_log[(ack_cnt - 1) % 64]}, 64'h0002);
        chk("abort_no_stale", stale + {31'd0, inst_valid}, 64'd0);

        // Reset in the middle of the FETCH_HI read
        n = 0;
        while (mem_addr !== 16'hC002 && n < 60) begin
            step();
            n++;
        end
        chk("hi_addr", {48'd0, mem_addr}, 64'hC002);
        chk("hi_req", {63'd0, mem_rd_req}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", {63'd0, mem_rd_req}, 64'd0);
        chk("mid_rst_valid", {63'd0, inst_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        step();
        rst       = 1'b0;
        ack_delay = 0;
        n         = 0;
        while (mem_rd_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("restart_req", {63'd0, mem_rd_req}, 64'd1);
        chk("restart_addr", {48'd0, mem_addr}, 64'h8000);
        chk("restart_cycles", n, 64'd1);
        wait_valid(n);
        chk("restart_opcode", {56'd0, inst_opcode}, 64'hA9);
        chk("req_hold_violations", hold_viol, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
